// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_bus_arbiter
// Purpose  : Shares one SPI byte engine between the flash loader (client 0) and
//            the SD/MMC controller (client 1), one chip-select transaction each.
// Options  : SPI_ARB_RR_EN - round-robin on tied claims (else client 0 priority)
// Revision : 1.0 - initial release
// ============================================================================

module spi_bus_arbiter #(
    parameter int CS_GAP = 2
) (
    input  logic       clk,
    input  logic       reset_n,

    input  logic       c0_claim,
    input  logic       c0_req,
    output logic       c0_ack,
    input  logic [7:0] c0_d,
    input  logic       c0_speed,
    output logic [7:0] c0_q,
    output logic       c0_cs_n,

    input  logic       c1_claim,
    input  logic       c1_req,
    output logic       c1_ack,
    input  logic [7:0] c1_d,
    input  logic       c1_speed,
    output logic [7:0] c1_q,
    output logic       c1_cs_n,

    output logic [1:0] grant,

    output logic       spi_req,
    input  logic       spi_ack,
    output logic [7:0] spi_d,
    input  logic [7:0] spi_q,
    output logic       spi_speed
);

    localparam logic [2:0] ST_SYNC = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_OWN  = 3'd2;
    localparam logic [2:0] ST_BUSY = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    localparam int              GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    logic [2:0]       r_state;
    logic             r_owner;
    logic [GAP_W-1:0] r_gap_cnt;

    logic       w_c0_pend;
    logic       w_c1_pend;
    logic       w_any_claim;
    logic       w_own_claim;
    logic       w_own_pend;
    logic [7:0] w_own_d;
    logic       w_own_speed;
    logic       w_pick;
    logic       w_byte_done;

    always_comb begin
        w_c0_pend   = c0_req ^ c0_ack;
        w_c1_pend   = c1_req ^ c1_ack;
        w_any_claim = c0_claim | c1_claim;
        w_byte_done = (spi_ack == spi_req);
    end

    // Everything the owner presents, selected by the registered owner index.
    always_comb begin
        w_own_claim = c0_claim;
        w_own_pend  = w_c0_pend;
        w_own_d     = c0_d;
        w_own_speed = c0_speed;
        if (r_owner) begin
            w_own_claim = c1_claim;
            w_own_pend  = w_c1_pend;
            w_own_d     = c1_d;
            w_own_speed = c1_speed;
        end
    end

`ifdef SPI_ARB_RR_EN
    logic r_last_owner;

    // Starts at client 1 so that client 0 wins the first tie after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_owner <= 1'b1;
        end else if (r_state == ST_IDLE && w_any_claim) begin
            r_last_owner <= w_pick;
        end
    end

    always_comb begin
        w_pick = c1_claim;
        if (c0_claim && c1_claim) begin
            w_pick = ~r_last_owner;
        end
    end
`else
    always_comb begin
        w_pick = ~c0_claim;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_SYNC;
            r_owner   <= 1'b0;
            r_gap_cnt <= '0;
            grant     <= 2'b00;
            c0_cs_n   <= 1'b1;
            c1_cs_n   <= 1'b1;
            spi_req   <= 1'b0;
        end else begin
            case (r_state)
                // The engine may have survived our reset mid-byte; adopt its
                // ack phase so a stale completion never reaches a client.
                ST_SYNC: begin
                    spi_req <= spi_ack;
                    r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (w_any_claim) begin
                        r_owner <= w_pick;
                        grant   <= w_pick ? 2'b10 : 2'b01;
                        c0_cs_n <= w_pick;
                        c1_cs_n <= ~w_pick;
                        r_state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (w_own_pend) begin
                        spi_req <= ~spi_req;
                        r_state <= ST_BUSY;
                    end else if (!w_own_claim) begin
                        grant     <= 2'b00;
                        c0_cs_n   <= 1'b1;
                        c1_cs_n   <= 1'b1;
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end
                end
                ST_BUSY: begin
                    if (w_byte_done) begin
                        r_state <= ST_OWN;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    grant   <= 2'b00;
                    c0_cs_n <= 1'b1;
                    c1_cs_n <= 1'b1;
                    r_state <= ST_SYNC;
                end
            endcase
        end
    end

    // Engine data and speed only move when a byte is launched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_d     <= 8'h00;
            spi_speed <= 1'b0;
        end else if (r_state == ST_OWN && w_own_pend) begin
            spi_d     <= w_own_d;
            spi_speed <= w_own_speed;
        end
    end

    // Completion and read data go back to the owner only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c0_ack <= 1'b0;
            c0_q   <= 8'h00;
            c1_ack <= 1'b0;
            c1_q   <= 8'h00;
        end else if (r_state == ST_BUSY && w_byte_done) begin
            if (r_owner) begin
                c1_q   <= spi_q;
                c1_ack <= ~c1_ack;
            end else begin
                c0_q   <= spi_q;
                c0_ack <= ~c0_ack;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_bus_arbiter
// Purpose  : Directed bench for spi_bus_arbiter with a toggle-handshake engine
//            model and per-client / per-engine expectation queues.
// Revision : 1.0 - initial release
// ============================================================================

module tb_spi_bus_arbiter;

    localparam int CS_GAP = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       c0_claim, c0_req, c0_speed, c1_claim, c1_req, c1_speed;
    logic [7:0] c0_d, c1_d;
    logic       c0_ack, c1_ack, c0_cs_n, c1_cs_n;
    logic [7:0] c0_q, c1_q;
    logic [1:0] grant;
    logic       spi_req, spi_ack, spi_speed;
    logic [7:0] spi_d, spi_q;

    int n_assert = 0;
    int n_fail   = 0;
    int n_spur   = 0;
    int acks0    = 0;
    int acks1    = 0;

    logic [15:0] exp_spi[$];
    logic [7:0]  exp_q0[$];
    logic [7:0]  exp_q1[$];

    logic       pa0, pa1;
    logic       eng_busy, eng_tgt, prev_req;
    logic [7:0] eng_d;
    int         eng_cnt;

    spi_bus_arbiter #(.CS_GAP(CS_GAP)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .c0_claim (c0_claim),
        .c0_req   (c0_req),
        .c0_ack   (c0_ack),
        .c0_d     (c0_d),
        .c0_speed (c0_speed),
        .c0_q     (c0_q),
        .c0_cs_n  (c0_cs_n),
        .c1_claim (c1_claim),
        .c1_req   (c1_req),
        .c1_ack   (c1_ack),
        .c1_d     (c1_d),
        .c1_speed (c1_speed),
        .c1_q     (c1_q),
        .c1_cs_n  (c1_cs_n),
        .grant    (grant),
        .spi_req  (spi_req),
        .spi_ack  (spi_ack),
        .spi_d    (spi_d),
        .spi_q    (spi_q),
        .spi_speed(spi_speed)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Engine model: not reset by the arbiter; answers d ^ 0xA6 five cycles
    // after a new request toggle.
    initial begin
        spi_ack  = 1'b0;
        spi_q    = 8'h00;
        eng_busy = 1'b0;
        eng_tgt  = 1'b0;
        eng_d    = 8'h00;
        eng_cnt  = 0;
        prev_req = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (eng_busy) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    spi_q    = eng_d ^ 8'hA6;
                    spi_ack  = eng_tgt;
                    eng_busy = 1'b0;
                end
            end else if (spi_req !== prev_req && spi_req !== spi_ack) begin
                eng_busy = 1'b1;
                eng_cnt  = 5;
                eng_tgt  = spi_req;
                eng_d    = spi_d;
                if (exp_spi.size() > 0)
                    chk("spi_xfer", {7'b0, spi_speed, spi_d}, exp_spi.pop_front());
                else
                    n_spur++;
            end
            prev_req = spi_req;
        end
    end

    // Client-side completion monitor.
    initial begin
        pa0 = 1'b0;
        pa1 = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pa0 = c0_ack;
                pa1 = c1_ack;
            end else begin
                if (c0_ack !== pa0) begin
                    acks0++;
                    pa0 = c0_ack;
                    if (exp_q0.size() > 0) chk("c0_q", 16'(c0_q), 16'(exp_q0.pop_front()));
                    else n_spur++;
                end
                if (c1_ack !== pa1) begin
                    acks1++;
                    pa1 = c1_ack;
                    if (exp_q1.size() > 0) chk("c1_q", 16'(c1_q), 16'(exp_q1.pop_front()));
                    else n_spur++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input int c, input logic [7:0] d, input logic sp, input bit push_q);
        if (c == 0) begin
            c0_d = d; c0_speed = sp; c0_req = ~c0_req;
            if (push_q) exp_q0.push_back(d ^ 8'hA6);
        end else begin
            c1_d = d; c1_speed = sp; c1_req = ~c1_req;
            if (push_q) exp_q1.push_back(d ^ 8'hA6);
        end
    endtask

    task automatic set_claim(input int c, input logic v);
        if (c == 0) c0_claim = v;
        else        c1_claim = v;
    endtask

    task automatic wait_ack(input int c);
        int k;
        k = 0;
        while (((c == 0) ? (c0_ack != c0_req) : (c1_ack != c1_req)) && k < 40) begin
            tick();
            k++;
        end
        if (c == 0) chk("ack0_done", 16'(c0_ack), 16'(c0_req));
        else        chk("ack1_done", 16'(c1_ack), 16'(c1_req));
    endtask

    initial begin
        int  first;
        int  gap;
        int  k;
        int  a0, a1;
        bit  early;

        reset_n  = 1'b0;
        c0_claim = 1'b0; c0_req = 1'b0; c0_d = 8'h00; c0_speed = 1'b0;
        c1_claim = 1'b0; c1_req = 1'b0; c1_d = 8'h00; c1_speed = 1'b0;
        ticks(3);
        chk("rst_cs_n",  16'({c0_cs_n, c1_cs_n}), 16'h3);
        chk("rst_grant", 16'(grant), 16'h0);
        chk("rst_acks",  16'({c0_ack, c1_ack}), 16'h0);
        chk("rst_q",     {c0_q, c1_q}, 16'h0);
        chk("rst_spi",   16'({spi_speed, spi_req, spi_d}), 16'h0);
        reset_n = 1'b1;
        tick();

        // Single byte on client 0
        exp_spi.push_back(16'h0003);
        send(0, 8'h03, 1'b0, 1'b1);
        c0_claim = 1'b1;
        tick();
        chk("t1_cs_n",        16'({c0_cs_n, c1_cs_n}), 16'h1);
        chk("t1_grant",       16'(grant), 16'h1);
        chk("t1_req_not_yet", 16'(spi_req), 16'h0);
        tick();
        chk("t1_spi_req", 16'(spi_req), 16'h1);
        chk("t1_spi_d",   16'(spi_d), 16'h03);
        wait_ack(0);
        chk("t1_q",       16'(c0_q), 16'hA5);
        chk("t1_c1_cs_n", 16'(c1_cs_n), 16'h1);
        c0_claim = 1'b0;
        tick();
        chk("t1_release", 16'({c0_cs_n, c1_cs_n, grant}), 16'hC);
        ticks(CS_GAP + 1);

        // Burst of four on client 1, then release
        a1 = acks1;
        c1_claim = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_spi.push_back(16'h0110 + 16'(i));
            send(1, 8'h10 + 8'(i), 1'b1, 1'b1);
            wait_ack(1);
            chk("t2_cs_held", 16'(c1_cs_n), 16'h0);
        end
        c1_claim = 1'b0;
        tick();
        chk("t2_ack_count",  16'(acks1 - a1), 16'h4);
        chk("t2_release",    16'({c0_cs_n, c1_cs_n, grant}), 16'hC);
        chk("t2_data_hold",  16'({spi_speed, spi_d}), 16'h113);
        ticks(CS_GAP + 1);

        // Contention: client 1 owned last, so client 0 wins in either mode
        exp_spi.push_back(16'h0021);
        send(0, 8'h21, 1'b0, 1'b1);
        send(1, 8'h31, 1'b1, 1'b1);
        c0_claim = 1'b1;
        c1_claim = 1'b1;
        tick();
        chk("t3_first_grant", 16'(grant), 16'h1);
        wait_ack(0);
        c0_claim = 1'b0;
        c1_claim = 1'b0;
        tick();
        chk("t3_release",    16'({c0_cs_n, c1_cs_n, grant}), 16'hC);
        chk("t3_c1_pending", 16'(c1_ack != c1_req), 16'h1);
        ticks(CS_GAP + 1);

        // Repeat contention: round-robin now favours client 1
`ifdef SPI_ARB_RR_EN
        first = 1;
        exp_spi.push_back(16'h0131);
        exp_spi.push_back(16'h0022);
`else
        first = 0;
        exp_spi.push_back(16'h0022);
        exp_spi.push_back(16'h0131);
`endif
        send(0, 8'h22, 1'b0, 1'b1);
        c0_claim = 1'b1;
        c1_claim = 1'b1;
        tick();
        chk("t3b_first_grant", 16'(grant), (first != 0) ? 16'h2 : 16'h1);
        wait_ack(first);
        set_claim(first, 1'b0);
        tick();
        chk("t3b_first_cs_high", 16'((first != 0) ? c1_cs_n : c0_cs_n), 16'h1);
        gap = 0;
        while (((first != 0) ? c0_cs_n : c1_cs_n) && gap < 20) begin
            tick();
            gap++;
        end
        chk("t3b_cs_gap", 16'(gap), 16'(CS_GAP + 1));
        wait_ack(1 - first);
        set_claim(1 - first, 1'b0);
        tick();
        chk("t3b_release", 16'({c0_cs_n, c1_cs_n, grant}), 16'hC);
        ticks(CS_GAP + 1);

        // Claim dropped mid-byte, with client 1 requesting but not owning
        exp_spi.push_back(16'h0044);
        send(0, 8'h44, 1'b0, 1'b1);
        send(1, 8'h55, 1'b1, 1'b1);
        c0_claim = 1'b1;
        ticks(2);
        chk("t5_in_flight", 16'(spi_req != spi_ack), 16'h1);
        c0_claim = 1'b0;
        early = 1'b0;
        k = 0;
        while (c0_ack != c0_req && k < 40) begin
            tick();
            k++;
            if (c0_ack != c0_req && c0_cs_n) early = 1'b1;
        end
        chk("t5_ack",          16'(c0_ack), 16'(c0_req));
        chk("t5_no_early_cs",  16'(early), 16'h0);
        chk("t5_cs_low_at_ack", 16'(c0_cs_n), 16'h0);
        tick();
        chk("t5_cs_rise",      16'(c0_cs_n), 16'h1);
        chk("t5_c1_untouched", {7'b0, c1_ack != c1_req, c1_q}, 16'h197);
        ticks(CS_GAP + 1);
        exp_spi.push_back(16'h0155);
        c1_claim = 1'b1;
        wait_ack(1);
        chk("t5_c1_q", 16'(c1_q), 16'hF3);
        c1_claim = 1'b0;
        ticks(CS_GAP + 2);

        // Reset while the engine is still working on a byte
        exp_spi.push_back(16'h0066);
        send(0, 8'h66, 1'b0, 1'b0);
        c0_claim = 1'b1;
        ticks(3);
        a0 = acks0;
        a1 = acks1;
        reset_n  = 1'b0;
        c0_claim = 1'b0;
        c0_req   = 1'b0;
        c1_req   = 1'b0;
        #1;
        chk("t6_rst_cs",   16'({c0_cs_n, c1_cs_n, grant}), 16'hC);
        chk("t6_rst_acks", {6'b0, c0_ack, c1_ack, c0_q}, 16'h0);
        chk("t6_rst_c1_q", 16'(c1_q), 16'h0);
        chk("t6_rst_spi",  16'({spi_speed, spi_req, spi_d}), 16'h0);
        ticks(8);
        reset_n = 1'b1;
        ticks(2);
        chk("t6_sync", 16'(spi_req), 16'(spi_ack));
        ticks(10);
        chk("t6_no_client_ack", 16'({c0_ack, c1_ack}), 16'h0);
        chk("t6_no_ack_events", 16'((acks0 - a0) + (acks1 - a1)), 16'h0);

        chk("spi_queue_drained", 16'(exp_spi.size()), 16'h0);
        chk("q_queue_drained",   16'(exp_q0.size() + exp_q1.size()), 16'h0);
        chk("no_spurious",       16'(n_spur), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
